// File: rtl/sign_narrower.sv
// Narrows signed IN_WIDTH words to OUT_WIDTH fields and queues them in a 2-entry buffer.
// Non-fitting values saturate by default; define SIGN_NARROWER_WRAP_EN to truncate instead.
module sign_narrower #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 13,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_ovf,
  output logic [CNT_WIDTH-1:0] ovf_count,
  output logic                 sticky_ovf,
  input  logic                 clr_ovf
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state;
  logic [OUT_WIDTH-1:0]   head_data, tail_data;
  logic                   head_ovf, tail_ovf;
  logic [IN_WIDTH-OUT_WIDTH:0] top_bits;
  logic                   fits;
  logic [OUT_WIDTH-1:0]   new_data;
  logic                   new_ovf;
  logic                   push, pop;

  // The value is representable when every bit from the output sign bit upward is a copy of the sign.
  always_comb begin
    top_bits = in_data[IN_WIDTH-1:OUT_WIDTH-1];
    fits     = (&top_bits) | ~(|top_bits);
    new_ovf  = ~fits;
    new_data = in_data[OUT_WIDTH-1:0];
`ifndef SIGN_NARROWER_WRAP_EN
    if (!fits) begin
      new_data = in_data[IN_WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
`endif
  end

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = head_data;
  assign out_ovf   = head_ovf;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // The head register is zeroed whenever the queue drains so outputs read 0 while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      head_data <= '0;
      head_ovf  <= 1'b0;
      tail_data <= '0;
      tail_ovf  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head_data <= new_data;
            head_ovf  <= new_ovf;
            state     <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_data <= new_data;
            head_ovf  <= new_ovf;
          end else if (push) begin
            tail_data <= new_data;
            tail_ovf  <= new_ovf;
            state     <= TWO;
          end else if (pop) begin
            head_data <= '0;
            head_ovf  <= 1'b0;
            state     <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head_data <= tail_data;
            head_ovf  <= tail_ovf;
            tail_data <= '0;
            tail_ovf  <= 1'b0;
            state     <= ONE;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

  // A clear takes effect before a coincident overflow event, so that event is still counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_count  <= '0;
      sticky_ovf <= 1'b0;
    end else if (clr_ovf) begin
      ovf_count  <= (push && new_ovf) ? CNT_ONE : '0;
      sticky_ovf <= push && new_ovf;
    end else if (push && new_ovf) begin
      sticky_ovf <= 1'b1;
      if (ovf_count != CNT_MAX) begin
        ovf_count <= ovf_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_sign_narrower.sv
// Randomized and directed bench for sign_narrower against a queue-based arithmetic model.
// Honours SIGN_NARROWER_WRAP_EN to select the expected overflow handling.
module tb_sign_narrower;

  localparam int IW = 32;
  localparam int OW = 13;
  localparam int CW = 8;
  localparam longint OMAX = (64'sd1 <<< (OW - 1)) - 1;
  localparam longint OMIN = -(64'sd1 <<< (OW - 1));
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_ovf;
  logic [CW-1:0] ovf_count;
  logic          sticky_ovf;
  logic          clr_ovf;

  int errors = 0;
  int checks = 0;

  logic [OW:0] mq[$];
  int          m_cnt;
  bit          m_sticky;

  always #5 clk = ~clk;

  sign_narrower #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
    .ovf_count(ovf_count), .sticky_ovf(sticky_ovf), .clr_ovf(clr_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference narrowing from plain signed arithmetic: {ovf, result}.
  function automatic logic [OW:0] ref_narrow(input logic [IW-1:0] d);
    longint v;
    longint r;
    bit     ovf;
    v   = longint'(signed'(d));
    ovf = (v > OMAX) || (v < OMIN);
    r   = v;
`ifndef SIGN_NARROWER_WRAP_EN
    if (v > OMAX) r = OMAX;
    if (v < OMIN) r = OMIN;
`endif
    r = r & ((64'sd1 <<< OW) - 1);
    return {ovf, r[OW-1:0]};
  endfunction

  task automatic check_outputs();
    logic [OW:0] head;
    head = (mq.size() > 0) ? mq[0] : '0;
    chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("out_data", 32'(out_data), 32'(head[OW-1:0]));
    chk("out_ovf", 32'(out_ovf), 32'(head[OW]));
    chk("ovf_count", 32'(ovf_count), 32'(m_cnt));
    chk("sticky_ovf", 32'(sticky_ovf), 32'(m_sticky));
  endtask

  // Check current outputs, take one clock edge, then advance the model.
  task automatic cycle();
    bit          push, pop;
    logic [OW:0] nw;
    check_outputs();
    push = in_valid && (mq.size() < 2);
    pop  = out_ready && (mq.size() > 0);
    nw   = ref_narrow(in_data);
    @(posedge clk);
    #1;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(nw);
    if (clr_ovf) begin
      m_cnt    = 0;
      m_sticky = 0;
    end
    if (push && nw[OW]) begin
      m_cnt    = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      m_sticky = 1;
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    chk("drained", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int list1[6];
    logic [IW-1:0] list2[6];
    logic [OW-1:0] exp2[6];

    list1 = '{10, 2237, -24, -1234, 3267, -3268};
    list2 = '{32'd4095, 32'd4096, 32'hFFFF_F000, 32'hFFFF_EFFF, 32'h7FFF_FFFF, 32'h8000_0000};
`ifdef SIGN_NARROWER_WRAP_EN
    exp2 = '{13'h0FFF, 13'h1000, 13'h1000, 13'h0FFF, 13'h1FFF, 13'h0000};
`else
    exp2 = '{13'h0FFF, 13'h0FFF, 13'h1000, 13'h1000, 13'h0FFF, 13'h1000};
`endif

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;
    mq.delete(); m_cnt = 0; m_sticky = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs();

    // In-range values pass through unchanged.
    out_ready = 1'b1;
    foreach (list1[i]) begin
      in_valid = 1'b1;
      in_data  = IW'(list1[i]);
      cycle();
      chk("pass_val", 32'(out_data), 32'(list1[i] & 32'h1FFF));
    end
    drain();

    // Boundary values with independently tabulated results.
    foreach (list2[i]) begin
      in_valid = 1'b1;
      in_data  = list2[i];
      cycle();
      chk("bound_val", 32'(out_data), 32'(exp2[i]));
    end
    drain();
    chk("bound_cnt", 32'(ovf_count), 32'd4);
    chk("bound_sticky", 32'(sticky_ovf), 32'd1);

    // Backpressure: third word waits while the head stays at 1.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd1; cycle();
    in_data   = 32'd2; cycle();
    in_data   = 32'd3; cycle();
    cycle();
    chk("bp_ready", 32'(in_ready), 32'd0);
    chk("bp_head", 32'(out_data), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (mq.size() == 1 && mq[0][OW-1:0] == 13'd3) in_valid = 1'b0;
    end
    drain();

    // Random streaming with random backpressure.
    for (int i = 0; i < 100; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = ($urandom_range(0, 1) == 1) ? $urandom : IW'(int'($urandom_range(0, 16000)) - 8000);
      cycle();
    end
    drain();

    // Counter saturation, then clear coinciding with an overflowing push.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = (i % 2 == 0) ? 32'h0001_0000 : 32'hFFF0_0000;
      cycle();
    end
    chk("cnt_sat", 32'(ovf_count), 32'd255);
    clr_ovf = 1'b1;
    in_data = 32'h4000_0000;
    cycle();
    clr_ovf  = 1'b0;
    in_valid = 1'b0;
    chk("clr_push_cnt", 32'(ovf_count), 32'd1);
    chk("clr_push_sticky", 32'(sticky_ovf), 32'd1);
    clr_ovf = 1'b1;
    cycle();
    clr_ovf = 1'b0;
    chk("clr_cnt", 32'(ovf_count), 32'd0);
    drain();

    // Asynchronous reset while the queue is full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0002_0000; cycle();
    in_data   = 32'd7; cycle();
    in_valid  = 1'b0;
    check_outputs();
    chk("full_before_rst", 32'(in_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_cnt", 32'(ovf_count), 32'd0);
    chk("rst_sticky", 32'(sticky_ovf), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    mq.delete(); m_cnt = 0; m_sticky = 0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hFFFF_FFFF;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("after_rst_data", 32'(out_data), 32'h1FFF);
    chk("after_rst_ovf", 32'(out_ovf), 32'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
